// File: rtl/ft600_tx_streamer_if.sv
// FT600/FT601 write-path bundle: upstream valid/ready stream plus
// the FT 245-sync bus pins driven by the streamer.
interface ft600_tx_streamer_if #(
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
);
  logic [DATA_W-1:0] s_data;
  logic [BE_W-1:0]   s_be;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] ft_data_o;
  logic [BE_W-1:0]   ft_be_o;
  logic              ft_oe_drv;
  logic              ft_wr_n;
  logic              ft_oe_n;
  logic              ft_rd_n;
  logic              ft_txe_n;

  modport master (
    output s_data, s_be, s_valid, ft_txe_n,
    input  s_ready, ft_data_o, ft_be_o,
    input  ft_oe_drv, ft_wr_n, ft_oe_n, ft_rd_n
  );

  modport slave (
    input  s_data, s_be, s_valid, ft_txe_n,
    output s_ready, ft_data_o, ft_be_o,
    output ft_oe_drv, ft_wr_n, ft_oe_n, ft_rd_n
  );
endinterface

// File: rtl/ft600_tx_streamer.sv
// FT600/FT601 write-path engine: stream -> FIFO -> registered FT bus.
// FT_PATTERN_GEN_EN builds the counter pattern source selected by gen_en.
module ft600_tx_streamer #(
  parameter int DATA_W     = 16,
  parameter int BE_W       = DATA_W / 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  ft600_tx_streamer_if.slave            bus,
  input  logic                          gen_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              tx_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [BE_W-1:0]   mem_be   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic              full;
  logic              empty;
  logic              ready;
  logic              push;
  logic              pop;
  logic              accept;
  logic [DATA_W-1:0] push_data;
  logic [BE_W-1:0]   push_be;

  logic              out_valid;
  logic              wr_n;
  logic [DATA_W-1:0] out_data;
  logic [BE_W-1:0]   out_be;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [BE_W-1:0]   be_nxt;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

`ifdef FT_PATTERN_GEN_EN
  logic [DATA_W-1:0] pat_cnt;
  logic              gen_push;

  always_comb begin
    ready     = ~full & ~rst & ~gen_en;
    gen_push  = gen_en & ~full;
    push      = gen_push |
                (bus.s_valid & ready & (|bus.s_be));
    push_data = gen_en ? pat_cnt : bus.s_data;
    push_be   = gen_en ? '1 : bus.s_be;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt <= '0;
    end else if (gen_push) begin
      pat_cnt <= pat_cnt + DATA_W'(1);
    end
  end
`else
  logic gen_unused;

  assign gen_unused = gen_en;

  always_comb begin
    ready     = ~full & ~rst;
    push      = bus.s_valid & ready & (|bus.s_be);
    push_data = bus.s_data;
    push_be   = bus.s_be;
  end
`endif

  assign accept = out_valid & ~bus.ft_txe_n;
  assign pop    = (~out_valid | accept) & ~empty;

  // a zero-BE beat is handshaken but never reaches the FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_be[wr_ptr]   <= push_be;
    end
  end

  always_comb begin
    valid_nxt = out_valid;
    data_nxt  = out_data;
    be_nxt    = out_be;
    unique case (1'b1)
      pop: begin
        valid_nxt = 1'b1;
        data_nxt  = mem_data[rd_ptr];
        be_nxt    = mem_be[rd_ptr];
      end
      accept & empty: begin
        valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      wr_n      <= 1'b1;
      out_data  <= '0;
      out_be    <= '0;
      tx_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop) level <= level + LW'(1);
      if (pop & ~push) level <= level - LW'(1);
      out_valid <= valid_nxt;
      wr_n      <= ~valid_nxt;
      out_data  <= data_nxt;
      out_be    <= be_nxt;
      if (accept) tx_count <= tx_count + CNT_W'(1);
    end
  end

  assign bus.s_ready   = ready;
  assign bus.ft_wr_n   = wr_n;
  assign bus.ft_oe_drv = out_valid;
  assign bus.ft_data_o = out_data;
  assign bus.ft_be_o   = out_be;
  assign bus.ft_oe_n   = 1'b1;
  assign bus.ft_rd_n   = 1'b1;
  assign fifo_level    = level;
endmodule

// File: tb/tb_ft600_tx_streamer.sv
// Directed bench for ft600_tx_streamer: latency, throughput, TXE stall,
// byte enables, reset mid-burst and (optionally) the pattern source.
module tb_ft600_tx_streamer;
  localparam int DW    = 16;
  localparam int BW    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          gen_en;
  logic [4:0]    fifo_level;
  logic [CW-1:0] tx_count;

  ft600_tx_streamer_if #(.DATA_W(DW), .BE_W(BW)) bus ();

  ft600_tx_streamer #(
    .DATA_W(DW), .BE_W(BW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .gen_en     (gen_en),
    .fifo_level (fifo_level),
    .tx_count   (tx_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] cap_d [$];
  logic [BW-1:0] cap_b [$];
  int            cap_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  // word presented with TXE low is taken by the chip at the next edge
  always @(negedge clk) begin
    if (!rst && !bus.ft_wr_n && !bus.ft_txe_n) begin
      cap_d.push_back(bus.ft_data_o);
      cap_b.push_back(bus.ft_be_o);
      cap_c.push_back(cyc);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_b.delete();
    cap_c.delete();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    gen_en      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_be    = '0;
    bus.ft_txe_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    clear_cap();
  endtask

  task automatic push_words(input logic [DW-1:0] first,
                            input int n,
                            input logic [BW-1:0] be);
    int   v = 0;
    int   guard = 0;
    logic go;
    while (v < n && guard < 400) begin
      bus.s_data  = first + DW'(v);
      bus.s_be    = be;
      bus.s_valid = 1'b1;
      go = bus.s_ready;
      tick(1);
      if (go) v++;
      guard++;
    end
    bus.s_valid = 1'b0;
    check("push_done", 64'(v), 64'(n));
  endtask

  task automatic check_seq(input string tag,
                           input logic [DW-1:0] first,
                           input int n);
    check({tag, "_cnt"}, 64'(cap_d.size()), 64'(n));
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i),
            64'(cap_d[i]), 64'(first + DW'(i)));
    end
  endtask

  initial begin
    // reset and idle
    rst          = 1'b1;
    gen_en       = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_be     = '0;
    bus.ft_txe_n = 1'b1;
    tick(2);
    check("rst_wr_n", 64'(bus.ft_wr_n), 64'd1);
    check("rst_oe_drv", 64'(bus.ft_oe_drv), 64'd0);
    check("rst_data", 64'(bus.ft_data_o), 64'd0);
    check("rst_ready", 64'(bus.s_ready), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_txcnt", 64'(tx_count), 64'd0);
    rst = 1'b0;
    tick(1);
    check("idle_ready", 64'(bus.s_ready), 64'd1);
    check("idle_wr_n", 64'(bus.ft_wr_n), 64'd1);
    check("rd_n_tie", 64'(bus.ft_rd_n), 64'd1);
    check("oe_n_tie", 64'(bus.ft_oe_n), 64'd1);
    clear_cap();

    // latency and back-to-back throughput
    bus.ft_txe_n = 1'b0;
    bus.s_be     = 2'b11;
    bus.s_valid  = 1'b1;
    bus.s_data   = 16'h0001;
    tick(1);
    check("lat_wr_n_e0", 64'(bus.ft_wr_n), 64'd1);
    check("lat_level_e0", 64'(fifo_level), 64'd1);
    bus.s_data = 16'h0002;
    tick(1);
    check("lat_wr_n_e1", 64'(bus.ft_wr_n), 64'd0);
    check("lat_data_e1", 64'(bus.ft_data_o), 64'h0001);
    check("lat_oe_drv_e1", 64'(bus.ft_oe_drv), 64'd1);
    for (int i = 3; i <= 8; i++) begin
      bus.s_data = DW'(i);
      tick(1);
    end
    bus.s_valid = 1'b0;
    tick(12);
    check("thr_txcnt", 64'(tx_count), 64'd8);
    check("thr_level", 64'(fifo_level), 64'd0);
    check("thr_wr_n", 64'(bus.ft_wr_n), 64'd1);
    check_seq("thr", 16'h0001, 8);
    check("thr_span",
          64'(cap_c.size() == 8 ? cap_c[7] - cap_c[0] : -1),
          64'd7);

    // TXE stall with FIFO filling up
    do_reset();
    bus.ft_txe_n = 1'b0;
    fork
      push_words(16'h0001, 24, 2'b11);
      begin
        int g = 0;
        while (tx_count != 3 && g < 100) begin
          tick(1);
          g++;
        end
        check("stall_start", 64'(tx_count), 64'd3);
        bus.ft_txe_n = 1'b1;
        tick(1);
        check("stall_wr_n0", 64'(bus.ft_wr_n), 64'd0);
        check("stall_data0", 64'(bus.ft_data_o), 64'h0004);
        tick(20);
        check("stall_wr_n1", 64'(bus.ft_wr_n), 64'd0);
        check("stall_data1", 64'(bus.ft_data_o), 64'h0004);
        check("stall_level", 64'(fifo_level), 64'd16);
        check("stall_ready", 64'(bus.s_ready), 64'd0);
        check("stall_txcnt", 64'(tx_count), 64'd3);
        bus.ft_txe_n = 1'b0;
      end
    join
    tick(30);
    check("stall_txcnt_end", 64'(tx_count), 64'd24);
    check("stall_level_end", 64'(fifo_level), 64'd0);
    check_seq("stall", 16'h0001, 24);

    // partial and zero byte enables
    do_reset();
    bus.ft_txe_n = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = 16'hAB00;
    bus.s_be     = 2'b10;
    tick(1);
    bus.s_data = 16'h1234;
    bus.s_be   = 2'b00;
    tick(1);
    bus.s_valid = 1'b0;
    tick(6);
    check("be_txcnt", 64'(tx_count), 64'd1);
    check("be_level", 64'(fifo_level), 64'd0);
    check("be_cnt", 64'(cap_d.size()), 64'd1);
    check("be_data",
          64'(cap_d.size() > 0 ? cap_d[0] : 16'hxxxx),
          64'hAB00);
    check("be_be",
          64'(cap_b.size() > 0 ? cap_b[0] : 2'bxx),
          64'd2);

    // reset in the middle of a burst
    do_reset();
    bus.ft_txe_n = 1'b1;
    push_words(16'h0100, 10, 2'b11);
    check("mid_level", 64'(fifo_level), 64'd9);
    check("mid_wr_n", 64'(bus.ft_wr_n), 64'd0);
    for (int i = 0; i < 4; i++) begin
      bus.ft_txe_n = ~bus.ft_txe_n;
      tick(1);
    end
    clear_cap();
    rst = 1'b1;
    bus.ft_txe_n = 1'b0;
    tick(1);
    check("mid_rst_wr_n", 64'(bus.ft_wr_n), 64'd1);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_oe", 64'(bus.ft_oe_drv), 64'd0);
    check("mid_rst_txcnt", 64'(tx_count), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(6);
    check("mid_post_txcnt", 64'(tx_count), 64'd0);
    check("mid_post_cap", 64'(cap_d.size()), 64'd0);
    check("mid_post_wr_n", 64'(bus.ft_wr_n), 64'd1);

`ifdef FT_PATTERN_GEN_EN
    begin
      int bad_rdy = 0;
      int bad_seq = 0;
      do_reset();
      bus.ft_txe_n = 1'b0;
      gen_en = 1'b1;
      repeat (300) begin
        tick(1);
        if (bus.s_ready !== 1'b0) bad_rdy++;
      end
      gen_en = 1'b0;
      tick(25);
      check("gen_ready", 64'(bad_rdy), 64'd0);
      check("gen_cnt", 64'(cap_d.size()), 64'd300);
      for (int i = 0; i < cap_d.size(); i++) begin
        if (cap_d[i] !== DW'(i)) bad_seq++;
      end
      check("gen_seq", 64'(bad_seq), 64'd0);
      check("gen_span",
            64'(cap_c.size() == 300 ? cap_c[299] - cap_c[0] : -1),
            64'd299);
      check("gen_txcnt", 64'(tx_count), 64'd300);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
